// File: rtl/mfhwt_pkg.sv
// Shared constants and state encoding for the mfhwt ping-pong buffer controllers.
package mfhwt_pkg;

    localparam int MFHWT_WIDTH = 640;
    localparam int MFHWT_ROWS  = 4;
    localparam int MFHWT_DW    = 16;

    localparam int COL_W = $clog2(MFHWT_WIDTH);
    localparam int ROW_W = $clog2(MFHWT_ROWS);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        FILL       = 2'd1,
        WAIT_DRAIN = 2'd2
    } state_e;

endpackage

// File: rtl/mfhwt_raster_cnt.sv
// Raster col/row counter with row wrap and bank-complete flag.
// iRestart forces col=row=0 for the current advance.
module mfhwt_raster_cnt
    import mfhwt_pkg::*;
#(
    parameter int WIDTH = MFHWT_WIDTH,
    parameter int ROWS  = MFHWT_ROWS,
    parameter int CW    = $clog2(WIDTH),
    parameter int RW    = $clog2(ROWS)
) (
    input  logic          iClk,
    input  logic          iRst,
    input  logic          iAdv,
    input  logic          iRestart,
    output logic [RW-1:0] oRow,
    output logic          oBankEnd
);

    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic [CW-1:0] col_eff;
    logic          row_end;

    assign col_eff  = iRestart ? '0 : col_q;
    assign oRow     = iRestart ? '0 : row_q;
    assign row_end  = (col_eff == CW'(WIDTH - 1));
    assign oBankEnd = row_end && (oRow == RW'(ROWS - 1));

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (iAdv) begin
            if (row_end) begin
                col_d = '0;
                row_d = oBankEnd ? '0 : oRow + 1'b1;
            end else begin
                col_d = col_eff + 1'b1;
                row_d = oRow;
            end
        end
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

endmodule

// File: rtl/mfhwt_ppbuf_wrctrl.sv
// Write-side controller for the 640x4 ping-pong line buffer.
// Optional MFHWT_WRCTRL_SOF_EN: accepted iSof restarts the current bank at row 0, col 0.
module mfhwt_ppbuf_wrctrl
    import mfhwt_pkg::*;
#(
    parameter int WIDTH = MFHWT_WIDTH,
    parameter int ROWS  = MFHWT_ROWS,
    parameter int DW    = MFHWT_DW
) (
    input  logic              iClk,
    input  logic              iRst,
    input  logic              iValid,
    input  logic [DW-1:0]     iData,
    input  logic              iSof,
    input  logic [2*ROWS-1:0] iFull,
    input  logic [1:0]        iEmpty,
    output logic              oReady,
    output logic [DW-1:0]     oData,
    output logic [2*ROWS-1:0] oWrreq,
    output logic              oSelect,
    output logic [1:0]        oBankDone,
    output logic              oOverflow
);

    localparam int RW = $clog2(ROWS);

    state_e state_q, state_d;
    logic   bank_q, bank_d;

    logic [DW-1:0]     data_q, data_d;
    logic [2*ROWS-1:0] wrreq_q, wrreq_d;
    logic              sel_q;
    logic [1:0]        done_q, done_d;
    logic              ovf_q, ovf_d;

    logic          accept;
    logic          restart;
    logic          bank_end;
    logic          other_empty;
    logic [RW-1:0] row;
    logic [RW:0]   idx;

    assign oReady      = (state_q == FILL);
    assign accept      = iValid && oReady;
    assign other_empty = iEmpty[~bank_q];
    assign idx         = {bank_q, row};

`ifdef MFHWT_WRCTRL_SOF_EN
    assign restart = accept && iSof;
`else
    logic sof_unused;
    assign sof_unused = iSof;
    assign restart    = 1'b0;
`endif

    mfhwt_raster_cnt #(
        .WIDTH(WIDTH),
        .ROWS (ROWS)
    ) u_cnt (
        .iClk    (iClk),
        .iRst    (iRst),
        .iAdv    (accept),
        .iRestart(restart),
        .oRow    (row),
        .oBankEnd(bank_end)
    );

    always_comb begin
        state_d = state_q;
        bank_d  = bank_q;
        unique case (state_q)
            IDLE: begin
                if (iEmpty == 2'b11) state_d = FILL;
            end
            FILL: begin
                if (accept && bank_end) begin
                    if (other_empty) bank_d  = ~bank_q;
                    else             state_d = WAIT_DRAIN;
                end
            end
            WAIT_DRAIN: begin
                if (other_empty) begin
                    state_d = FILL;
                    bank_d  = ~bank_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // The write is issued even into a full row; only the sticky flag records it.
    always_comb begin
        data_d  = accept ? iData : data_q;
        wrreq_d = accept ? ((2*ROWS)'(1) << idx) : '0;
        done_d  = (accept && bank_end) ? (bank_q ? 2'b10 : 2'b01) : 2'b00;
        ovf_d   = ovf_q | (accept & iFull[idx]);
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state_q <= IDLE;
            bank_q  <= 1'b0;
            data_q  <= '0;
            wrreq_q <= '0;
            sel_q   <= 1'b0;
            done_q  <= 2'b00;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            bank_q  <= bank_d;
            data_q  <= data_d;
            wrreq_q <= wrreq_d;
            sel_q   <= bank_q;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
        end
    end

    assign oData     = data_q;
    assign oWrreq    = wrreq_q;
    assign oSelect   = sel_q;
    assign oBankDone = done_q;
    assign oOverflow = ovf_q;

endmodule

// File: tb/tb_mfhwt_ppbuf_wrctrl.sv
// Bench for mfhwt_ppbuf_wrctrl: pixel-count model plus directed literal checks.
module tb_mfhwt_ppbuf_wrctrl;

    localparam int W    = 640;
    localparam int R    = 4;
    localparam int BANK = W * R;
`ifdef MFHWT_WRCTRL_SOF_EN
    localparam bit SOF_EN = 1'b1;
`else
    localparam bit SOF_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        iValid = 1'b0;
    logic [15:0] iData = '0;
    logic        iSof = 1'b0;
    logic [7:0]  iFull = '0;
    logic [1:0]  iEmpty = 2'b11;
    logic        oReady;
    logic [15:0] oData;
    logic [7:0]  oWrreq;
    logic        oSelect;
    logic [1:0]  oBankDone;
    logic        oOverflow;

    mfhwt_ppbuf_wrctrl dut (
        .iClk     (clk),
        .iRst     (rst),
        .iValid   (iValid),
        .iData    (iData),
        .iSof     (iSof),
        .iFull    (iFull),
        .iEmpty   (iEmpty),
        .oReady   (oReady),
        .oData    (oData),
        .oWrreq   (oWrreq),
        .oSelect  (oSelect),
        .oBankDone(oBankDone),
        .oOverflow(oOverflow)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, a, e, $time);
        end
    endtask

    // Model: mode 0 waits for both banks empty, 1 fills, 2 waits for drain.
    int          m_mode = 0;
    int          m_bank = 0;
    int          m_cnt  = 0;
    logic [7:0]  e_wr   = '0;
    logic [15:0] e_data = '0;
    logic        e_sel  = 1'b0;
    logic [1:0]  e_done = '0;
    logic        e_ovf  = 1'b0;

    task automatic model_step();
        int  idx;
        bit  acc;
        if (rst) begin
            m_mode = 0; m_bank = 0; m_cnt = 0;
            e_wr = '0; e_data = '0; e_sel = 1'b0; e_done = '0; e_ovf = 1'b0;
        end else begin
            acc    = iValid && (m_mode == 1);
            e_sel  = m_bank[0];
            e_wr   = '0;
            e_done = '0;
            if (acc) begin
                if (SOF_EN && iSof) m_cnt = 0;
                idx    = m_bank * R + m_cnt / W;
                e_wr   = 8'(1 << idx);
                e_data = iData;
                if (iFull[idx]) e_ovf = 1'b1;
                m_cnt++;
                if (m_cnt == BANK) begin
                    e_done = (m_bank == 1) ? 2'b10 : 2'b01;
                    m_cnt  = 0;
                    if (iEmpty[1-m_bank]) m_bank = 1 - m_bank;
                    else                  m_mode = 2;
                end
            end else if (m_mode == 0) begin
                if (iEmpty == 2'b11) m_mode = 1;
            end else if (m_mode == 2) begin
                if (iEmpty[1-m_bank]) begin
                    m_mode = 1;
                    m_bank = 1 - m_bank;
                end
            end
        end
    endtask

    initial forever begin
        @(posedge clk or posedge rst);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        chk("m_ready", {31'd0, oReady}, {31'd0, m_mode == 1});
        chk("m_wrreq", {24'd0, oWrreq}, {24'd0, e_wr});
        chk("m_data", {16'd0, oData}, {16'd0, e_data});
        chk("m_select", {31'd0, oSelect}, {31'd0, e_sel});
        chk("m_bankdone", {30'd0, oBankDone}, {30'd0, e_done});
        chk("m_overflow", {31'd0, oOverflow}, {31'd0, e_ovf});
    end

    int nacc    = 0;
    int cyc     = 0;
    int sof_at  = -1;
    int full_lo = -1;
    int full_hi = -1;
    bit pend    = 1'b0;
    bit vld_en  = 1'b0;

    task automatic step();
        @(negedge clk);
        cyc++;
        if (pend) nacc++;
        iValid = vld_en && (cyc % 7 != 3);
        iData  = 16'(nacc);
        iSof   = (nacc == sof_at);
        iFull  = (nacc >= full_lo && nacc < full_hi) ? 8'h04 : 8'h00;
        pend   = iValid && oReady;
    endtask

    task automatic timeout(input string nm);
        total++;
        bad++;
        $display("FAIL %s: bounded wait expired at %0t", nm, $time);
    endtask

    task automatic wait_wr(input string nm, input int bound);
        bit ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            step();
            if (oWrreq != 0) begin ok = 1'b1; break; end
        end
        if (!ok) timeout(nm);
    endtask

    task automatic wait_data(input string nm, input int val, input int bound);
        bit ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            step();
            if (oWrreq != 0 && oData == 16'(val)) begin ok = 1'b1; break; end
        end
        if (!ok) timeout(nm);
    endtask

    task automatic wait_done(input string nm, input int bound);
        bit ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            step();
            if (oBankDone != 0) begin ok = 1'b1; break; end
        end
        if (!ok) timeout(nm);
    endtask

    int base;

    initial begin
        rst = 1'b0;
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_ready", {31'd0, oReady}, 32'd0);
        chk("rst_wrreq", {24'd0, oWrreq}, 32'd0);
        chk("rst_select", {31'd0, oSelect}, 32'd0);
        chk("rst_overflow", {31'd0, oOverflow}, 32'd0);
        chk("rst_data", {16'd0, oData}, 32'd0);

        full_lo = 2 * W + 10;
        full_hi = 2 * W + 20;
        vld_en  = 1'b1;
        rst     = 1'b0;

        wait_wr("first_wr", 20);
        chk("first_wrreq", {24'd0, oWrreq}, 32'h01);
        chk("first_data", {16'd0, oData}, 32'd0);
        wait_wr("second_wr", 20);
        chk("second_data", {16'd0, oData}, 32'd1);

        wait_done("b0_done", 4000);
        chk("b0_done", {30'd0, oBankDone}, 32'h1);
        chk("b0_last_wrreq", {24'd0, oWrreq}, 32'h08);
        chk("b0_last_select", {31'd0, oSelect}, 32'd0);
        chk("ovf_sticky", {31'd0, oOverflow}, 32'd1);
        iEmpty = 2'b10;
        step();
        chk("select_after_swap", {31'd0, oSelect}, 32'd1);
        if (oWrreq == 0) wait_wr("b1_first_wr", 20);
        chk("b1_first_wrreq", {24'd0, oWrreq}, 32'h10);

        wait_done("b1_done", 4000);
        chk("b1_done", {30'd0, oBankDone}, 32'h2);
        chk("b1_last_wrreq", {24'd0, oWrreq}, 32'h80);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("wait_ready", {31'd0, oReady}, 32'd0);
        end
        iEmpty = 2'b11;
        chk("drain_k_ready", {31'd0, oReady}, 32'd0);
        step();
        chk("drain_k1_ready", {31'd0, oReady}, 32'd1);
        sof_at = 2 * BANK + W + 300;
        wait_wr("after_drain_wr", 20);
        chk("after_drain_wrreq", {24'd0, oWrreq}, 32'h01);

        wait_data("sof_wr", sof_at, 2000);
        chk("sof_wrreq", {24'd0, oWrreq}, SOF_EN ? 32'h01 : 32'h02);
        wait_data("sof_next", sof_at + 639, 2000);
        chk("sof_next_wrreq", {24'd0, oWrreq}, SOF_EN ? 32'h01 : 32'h04);

        wait_done("b0b_done", 4000);
        chk("b0b_done", {30'd0, oBankDone}, 32'h1);
        base = nacc;
        for (int i = 0; i < 4000 && nacc < base + 3 * W + 100; i++) step();
        chk("pre_rst_select", {31'd0, oSelect}, 32'd1);
        chk("pre_rst_overflow", {31'd0, oOverflow}, 32'd1);
        #2 rst = 1'b1;
        pend = 1'b0;
        #1;
        chk("async_wrreq", {24'd0, oWrreq}, 32'd0);
        chk("async_select", {31'd0, oSelect}, 32'd0);
        chk("async_ready", {31'd0, oReady}, 32'd0);
        chk("async_overflow", {31'd0, oOverflow}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        wait_wr("restart_wr", 20);
        chk("restart_wrreq", {24'd0, oWrreq}, 32'h01);
        repeat (5) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/mfhwt_ppbuf_wrctrl.md
Name: mfhwt_ppbuf_wrctrl

Overview:
- Write-side controller directly upstream of the 640x4 ping-pong line buffer.
- Accepts a raster pixel stream (valid/ready) and drives the buffer's 16-bit data, 8-bit one-hot per-row write requests and bank select.
- Fills one bank (4 rows x WIDTH pixels) while the downstream wavelet stage drains the other bank, then swaps banks.
- Stalls the source when the other bank has not yet drained.

Parameters:
- WIDTH, 640, pixels per row; number of writes to each row FIFO.
- ROWS, 4, rows per bank; fixed by the buffer's 4 FIFOs per bank.
- DW, 16, pixel width in bits.

Ports:
- iClk  in  1  clock; all logic on the rising edge.
- iRst  in  1  reset; asynchronous assert, active-high.
- iValid  in  1  source pixel valid.
- iData  in  DW  source pixel.
- iSof  in  1  start-of-frame qualifier, sampled with iValid (see Optional Feature).
- iFull  in  8  buffer full flags: [3:0] bank0 rows, [7:4] bank1 rows.
- iEmpty  in  2  buffer empty flags, one per bank.
- oReady  out  1  pixel accepted when iValid && oReady.
- oData  out  DW  registered pixel to the buffer.
- oWrreq  out  8  registered one-hot row write request; bit = bank*4+row.
- oSelect  out  1  bank select to the buffer: 0 = write bank0 / read bank1.
- oBankDone  out  2  one-cycle pulse when the bank's last write is issued.
- oOverflow  out  1  sticky: a write was issued to a row whose iFull was set.

Behaviour:
- Reset (async, iRst=1): state IDLE, col=0, row=0, bank=0; oData=0, oWrreq=0, oSelect=0, oBankDone=0, oOverflow=0, oReady=0.
- oReady is combinational: 1 only in state FILL.
- States:
  - IDLE: stays until iEmpty==2'b11, then FILL.
  - FILL: accepts pixels.
  - WAIT_DRAIN: entered when a bank completes but bank ~bank is not empty (iEmpty[~bank]==0). Exits to FILL on the first cycle iEmpty[~bank]==1, toggling bank that same edge.
- Accept (iValid && oReady): next edge, oData<=iData and oWrreq<=1<<(bank*4+row); otherwise oWrreq<=0 and oData holds. Latency from accept to buffer write request is 1 cycle.
- Counters:
  - col increments per accept; at WIDTH-1 it wraps to 0 and row increments.
  - At row==ROWS-1 and col==WIDTH-1, row wraps to 0 and the bank is complete.
- Bank complete:
  - If iEmpty[~bank]==1 in that cycle, bank toggles at the same edge and the state stays FILL (back-to-back, zero bubble).
  - Otherwise the state goes to WAIT_DRAIN and bank is unchanged.
- oSelect is bank delayed by one register, so it stays aligned with oWrreq/oData. The last write of a bank therefore still sees the old select. The buffer gates wrreq with select, so no write may straddle a swap.
- oBankDone[b] pulses in the same cycle the final oWrreq bit of bank b is asserted.
- oOverflow sets when an accepted pixel targets a row whose iFull bit is 1; it is cleared only by reset. The write is still issued.
- Simultaneous iValid during IDLE/WAIT_DRAIN: not accepted (oReady=0) and the source holds.
- Reset mid-row: counters, bank and outputs clear immediately. The partial row left in the buffer is the buffer's concern; the buffer is reset by the same iRst.

Optional Feature:
- MFHWT_WRCTRL_SOF_EN defined: an accepted pixel with iSof=1 forces col=row=0 before the write. That pixel is written to row 0, col 0 of the current bank, and col then becomes 1. Rows already written in the bank are abandoned, and the bank is not toggled.
- Not defined: iSof is ignored. The port remains present so top-level wiring is unchanged.

Decomposition:
- Shared package mfhwt_pkg holds:
  - constants MFHWT_WIDTH=640, MFHWT_ROWS=4, MFHWT_DW=16;
  - COL_W=$clog2(WIDTH), ROW_W=$clog2(ROWS);
  - state encoding IDLE=0, FILL=1, WAIT_DRAIN=2.
- One natural sub-module: mfhwt_raster_cnt, the col/row counter with wrap and bank-complete flags, reusable by the read-side controller.

Test Plan:
- Reset release with iEmpty=2'b11, iValid=1, iData=n: first oWrreq=8'h01 one cycle after first accept; oData=0 then 1,2,...
- Stream 2560 pixels: oWrreq walks 01,02,04,08 (640 each), oBankDone=2'b01 on the 2560th write, oSelect=1 on the next cycle, next write oWrreq=8'h10.
- After bank0 completes with iEmpty[1]=0: oReady=0 (WAIT_DRAIN). Raise iEmpty[1] at cycle k: oReady=1 at k+1 and the next write goes to bank1.
- Hold iFull[2]=1 while writing row 2 of bank0: oOverflow=1 and stays 1 after iFull drops; only iRst clears it.
- With MFHWT_WRCTRL_SOF_EN, iSof=1 at row 1, col 300: that pixel gets oWrreq=8'h01, and the next 639 pixels go to row 0. Without the macro, the same pixel gets oWrreq=8'h02.
- Assert iRst mid-row 3 of bank1: oWrreq=0 and oSelect=0 asynchronously; after release, writes restart at 8'h01.
